// File: rtl/multicycle_adder_pkg.sv
// Shared definitions for the multi-cycle adder/subtractor.
//   adder_state_t : FSM states (IDLE, RUN, DONE).
//   idx_width()   : width of the chunk index register, $clog2(nchunk) with a
//                   floor of 1 so a single-chunk build still gets a legal
//                   vector.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } adder_state_t;

  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/multicycle_adder_if.sv
// Operand/result handshake bundle for multicycle_adder.
//   Operand side : in_valid, in_ready, a, b, cin, sub
//   Result side  : out_valid, out_ready, sum, cout, ovf
// master = producer/consumer driving the adder, slave = the adder itself.
interface multicycle_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/multicycle_adder_chunk.sv
// adder_chunk: combinational CHUNK-bit ripple of full adders.
//   a, b  : chunk operands
//   cin   : carry into bit 0
//   sum   : chunk sum
//   cout  : carry out of the top bit
//   c_msb : carry into the top bit (feeds signed overflow on the last chunk)
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  // NOTE: blocking assignments here so each bit sees the carry computed by
  // the previous loop iteration; the ripple is evaluated in order.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/multicycle_adder.sv
// multicycle_adder: WIDTH-bit adder/subtractor processed CHUNK bits per clock
// through one shared adder_chunk slice, carry held in a register between
// cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of multicycle_adder_if (operand and result
//                valid/ready handshakes, sum, cout, ovf)
// Subtraction is A + ~B + 1: B is inverted at accept and the carry register
// is seeded with 1. in_ready/out_valid come straight from flops.
module multicycle_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_adder_if.slave     bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  adder_state_t     state_q, state_d;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q, ovf_q;
  logic             in_ready_q, out_valid_q;

  logic             accept;
  logic             last_chunk;
  logic [CHUNK-1:0] a_slice, b_slice, ch_sum;
  logic             ch_cout, ch_cmsb;

  // in_ready_q is low through reset and the first clock after release, so
  // gate acceptance on it rather than on the state alone.
  assign accept     = (state_q == IDLE) && in_ready_q && bus.in_valid;
  assign last_chunk = (idx_q == LAST_IDX);

  assign a_slice = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign b_slice = b_q[int'(idx_q)*CHUNK +: CHUNK];

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_slice),
    .b     (b_slice),
    .cin   (carry_q),
    .sum   (ch_sum),
    .cout  (ch_cout),
    .c_msb (ch_cmsb)
  );

  // NOTE: every variable written in this block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)         state_d = RUN;
      RUN:     if (last_chunk)     state_d = DONE;
      DONE:    if (bus.out_ready)  state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  // NOTE: these are plain registers, not a memory array, so all of them are
  // reset; an aborted operation leaves nothing stale visible on sum/cout/ovf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub ? 1'b1 : bus.cin;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q[int'(idx_q)*CHUNK +: CHUNK] <= ch_sum;
          carry_q <= ch_cout;
          if (last_chunk) begin
            cout_q <= ch_cout;
            ovf_q  <= ch_cout ^ ch_cmsb;
            idx_q  <= '0;
          end else begin
            idx_q  <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Self-checking bench for multicycle_adder (WIDTH=16, CHUNK=4).
// Expected results come from an integer-arithmetic model of A+B+cin / A-B.
module tb_multicycle_adder;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;

  logic clk;
  logic rst_n;

  multicycle_adder_if #(.WIDTH(WIDTH)) bus ();

  multicycle_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_sum;
  logic        exp_cout;
  logic        exp_ovf;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned sum for result/carry, signed integer range for overflow.
  task automatic model(input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub,
                       output logic [15:0] s, output logic co, output logic ov);
    int u;
    int sv;
    if (sub) begin
      u  = int'(a) + (65536 - int'(b));
      sv = int'($signed(a)) - int'($signed(b));
    end else begin
      u  = int'(a) + int'(b) + int'(cin);
      sv = int'($signed(a)) + int'($signed(b)) + int'(cin);
    end
    s  = u[15:0];
    co = u[16];
    ov = (sv > 32767) || (sv < -32768);
  endtask

  // Called at a negedge. hold=1 leaves the result undelivered (out_ready=0).
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub, input bit hold);
    int n;
    model(a, b, cin, sub, exp_sum, exp_cout, exp_ovf);
    bus.a         = a;
    bus.b         = b;
    bus.cin       = cin;
    bus.sub       = sub;
    bus.in_valid  = 1'b1;
    bus.out_ready = !hold;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 16'($urandom);
    bus.b        = 16'($urandom);
    bus.cin      = 1'($urandom);
    bus.sub      = 1'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 50);
    check("latency", 32'(n - 1), 32'd4);
    check("out_valid", 32'(bus.out_valid), 32'd1);
    check("sum", 32'(bus.sum), 32'(exp_sum));
    check("cout", 32'(bus.cout), 32'(exp_cout));
    check("ovf", 32'(bus.ovf), 32'(exp_ovf));
    if (!hold) begin
      @(negedge clk);
      check("out_valid_drop", 32'(bus.out_valid), 32'd0);
      check("in_ready_back", 32'(bus.in_ready), 32'd1);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    rst_n         = 1'b1;
    #1 rst_n      = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed cases
    do_op(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0);
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
    do_op(16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0);
    do_op(16'h1234, 16'h0000, 1'b1, 1'b1, 1'b0);

    // Randomized operations
    for (int i = 0; i < 20; i++) begin
      do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end

    // Backpressure: result held while new operands are offered
    do_op(16'hABCD, 16'h1357, 1'b1, 1'b0, 1'b1);
    bus.in_valid = 1'b1;
    bus.a        = 16'h0F0F;
    bus.b        = 16'hF0F0;
    bus.cin      = 1'b1;
    bus.sub      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_sum", 32'(bus.sum), 32'(exp_sum));
      check("bp_cout", 32'(bus.cout), 32'(exp_cout));
      check("bp_ovf", 32'(bus.ovf), 32'(exp_ovf));
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("bp_not_captured", 32'(bus.in_ready), 32'd1);

    // Reset during RUN at idx=2
    bus.a        = 16'h1111;
    bus.b        = 16'h2222;
    bus.cin      = 1'b0;
    bus.sub      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_after", 32'(bus.in_ready), 32'd1);
    check("abort_no_result", 32'(bus.out_valid), 32'd0);
    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
    check("after_abort_sum", 32'(exp_sum), 32'h0100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
